// File: rtl/ufifo_lvl.sv
// ufifo_lvl: synchronous single-clock FIFO with first-word-fall-through head,
// exact fill count, programmable almost-full level and sticky error flags.
//
// Optional feature: define UFIFO_HWM_EN to add the o_hwm high-water-mark port.
//
// Ports:
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_wr, i_data     write request and data
//   i_rd             read (pop) request
//   o_data           head-of-queue word, valid while o_empty_n
//   o_empty_n        FIFO holds at least one entry
//   o_full           fill == FLEN
//   o_half_full      fill >= FLEN/2
//   i_afull_lvl      almost-full threshold
//   o_afull          fill >= i_afull_lvl
//   o_fill           current entry count, 0..FLEN
//   i_clr_err        clears sticky error flags (and the high-water mark)
//   o_ovfl, o_unfl   sticky rejected-write / rejected-read flags
//   o_err            o_ovfl | o_unfl
//   o_hwm            high-water mark (UFIFO_HWM_EN only)
//   o_status         {LGFLEN[3:0], fill[8:0], err, half_full, empty_n}
module ufifo_lvl #(
    parameter int unsigned BW     = 8,
    parameter int unsigned LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr,
    input  logic [BW-1:0]     i_data,
    input  logic              i_rd,
    output logic [BW-1:0]     o_data,
    output logic              o_empty_n,
    output logic              o_full,
    output logic              o_half_full,
    input  logic [LGFLEN:0]   i_afull_lvl,
    output logic              o_afull,
    output logic [LGFLEN:0]   o_fill,
    input  logic              i_clr_err,
    output logic              o_ovfl,
    output logic              o_unfl,
    output logic              o_err,
`ifdef UFIFO_HWM_EN
    output logic [LGFLEN:0]   o_hwm,
`endif
    output logic [15:0]       o_status
);

    localparam int unsigned FLEN = 1 << LGFLEN;
    localparam int unsigned PW   = LGFLEN + 1;
    localparam int unsigned AW   = LGFLEN;

    logic [BW-1:0] mem_q [FLEN];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] fill_q, fill_d;
    logic [BW-1:0] data_q, data_d;
    logic          empty_n_q, empty_n_d;
    logic          full_q, full_d;
    logic          half_q, half_d;
    logic          afull_q, afull_d;
    logic          ovfl_q, ovfl_d;
    logic          unfl_q, unfl_d;
    logic          wr_acc, rd_acc;
    logic [AW-1:0] rd_nxt_addr;

    // Acceptance, pointer advance and registered-flag next values
    always_comb begin
        wr_acc      = i_wr & (~full_q | i_rd);
        rd_acc      = i_rd & empty_n_q;
        wr_ptr_d    = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d    = rd_ptr_q + PW'(rd_acc);
        // Pointer difference with the extra MSB gives the exact count 0..FLEN
        fill_d      = wr_ptr_d - rd_ptr_d;
        empty_n_d   = (fill_d != '0);
        full_d      = (fill_d == PW'(FLEN));
        half_d      = (fill_d >= PW'(FLEN / 2));
        afull_d     = (fill_d >= i_afull_lvl);
        ovfl_d      = (ovfl_q & ~i_clr_err) | (i_wr & ~wr_acc);
        unfl_d      = (unfl_q & ~i_clr_err) | (i_rd & ~rd_acc);
        rd_nxt_addr = rd_ptr_q[AW-1:0] + AW'(1);
    end

    // Head register: holds unless a pop exposes the next entry or an empty FIFO is written
    always_comb begin
        data_d = data_q;
        if (rd_acc) begin
            // With a single entry left, the only possible successor is this cycle's write
            data_d = (fill_q == PW'(1)) ? i_data : mem_q[rd_nxt_addr];
        end else if (wr_acc && !empty_n_q) begin
            data_d = i_data;
        end
    end

    // Storage array; contents are intentionally not reset
    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

    // Pointers, count, head and flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            data_q    <= '0;
            empty_n_q <= 1'b0;
            full_q    <= 1'b0;
            half_q    <= 1'b0;
            afull_q   <= 1'b0;
            ovfl_q    <= 1'b0;
            unfl_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            data_q    <= data_d;
            empty_n_q <= empty_n_d;
            full_q    <= full_d;
            half_q    <= half_d;
            afull_q   <= afull_d;
            ovfl_q    <= ovfl_d;
            unfl_q    <= unfl_d;
        end
    end

`ifdef UFIFO_HWM_EN
    logic [PW-1:0] hwm_q, hwm_d;

    // Running maximum of the fill; a clear restarts it from the current fill
    always_comb begin
        hwm_d = hwm_q;
        if (i_clr_err) begin
            hwm_d = fill_d;
        end else if (fill_d > hwm_q) begin
            hwm_d = fill_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign o_hwm = hwm_q;
`endif

    assign o_data      = data_q;
    assign o_empty_n   = empty_n_q;
    assign o_full      = full_q;
    assign o_half_full = half_q;
    assign o_afull     = afull_q;
    assign o_fill      = fill_q;
    assign o_ovfl      = ovfl_q;
    assign o_unfl      = unfl_q;
    assign o_err       = ovfl_q | unfl_q;
    assign o_status    = {4'(LGFLEN), 9'(fill_q), ovfl_q | unfl_q, half_q, empty_n_q};

endmodule

// File: tb/tb_ufifo_lvl.sv
// Testbench for ufifo_lvl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based reference model.
module tb_ufifo_lvl;

    localparam int unsigned BW     = 8;
    localparam int unsigned LGFLEN = 4;
    localparam int unsigned FLEN   = 1 << LGFLEN;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_wr;
    logic [BW-1:0]     i_data;
    logic              i_rd;
    logic [BW-1:0]     o_data;
    logic              o_empty_n;
    logic              o_full;
    logic              o_half_full;
    logic [LGFLEN:0]   i_afull_lvl;
    logic              o_afull;
    logic [LGFLEN:0]   o_fill;
    logic              i_clr_err;
    logic              o_ovfl;
    logic              o_unfl;
    logic              o_err;
    logic [15:0]       o_status;
`ifdef UFIFO_HWM_EN
    logic [LGFLEN:0]   o_hwm;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    ufifo_lvl #(.BW(BW), .LGFLEN(LGFLEN)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wr        (i_wr),
        .i_data      (i_data),
        .i_rd        (i_rd),
        .o_data      (o_data),
        .o_empty_n   (o_empty_n),
        .o_full      (o_full),
        .o_half_full (o_half_full),
        .i_afull_lvl (i_afull_lvl),
        .o_afull     (o_afull),
        .o_fill      (o_fill),
        .i_clr_err   (i_clr_err),
        .o_ovfl      (o_ovfl),
        .o_unfl      (o_unfl),
        .o_err       (o_err),
`ifdef UFIFO_HWM_EN
        .o_hwm       (o_hwm),
`endif
        .o_status    (o_status)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of words plus the sticky state
    logic [BW-1:0] mq[$];
    bit            m_ovfl  = 0;
    bit            m_unfl  = 0;
    bit            m_afull = 0;
    int            m_hwm   = 0;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mq.delete();
            m_ovfl  = 0;
            m_unfl  = 0;
            m_afull = 0;
            m_hwm   = 0;
        end else begin
            int  sz;
            bit  wa, ra;
            sz = mq.size();
            wa = i_wr && (sz < FLEN || i_rd);
            ra = i_rd && sz > 0;
            m_ovfl = (m_ovfl && !i_clr_err) || (i_wr && !wa);
            m_unfl = (m_unfl && !i_clr_err) || (i_rd && !ra);
            if (ra) void'(mq.pop_front());
            if (wa) mq.push_back(i_data);
            sz = mq.size();
            m_afull = (sz >= int'(i_afull_lvl));
            m_hwm   = i_clr_err ? sz : ((sz > m_hwm) ? sz : m_hwm);
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge i_clk) begin
        int          sz;
        logic [15:0] st;
        sz = mq.size();
        st = 16'(LGFLEN << 12) | 16'(sz << 3) | 16'((m_ovfl || m_unfl) << 2)
           | 16'((sz >= FLEN / 2) << 1) | 16'(sz > 0);
        chk("m_fill",    32'(o_fill),      32'(sz));
        chk("m_empty_n", 32'(o_empty_n),   32'(sz > 0));
        chk("m_full",    32'(o_full),      32'(sz == FLEN));
        chk("m_half",    32'(o_half_full), 32'(sz >= FLEN / 2));
        chk("m_afull",   32'(o_afull),     32'(m_afull));
        chk("m_ovfl",    32'(o_ovfl),      32'(m_ovfl));
        chk("m_unfl",    32'(o_unfl),      32'(m_unfl));
        chk("m_err",     32'(o_err),       32'(m_ovfl || m_unfl));
        chk("m_status",  32'(o_status),    32'(st));
        if (sz > 0) chk("m_data", 32'(o_data), 32'(mq[0]));
`ifdef UFIFO_HWM_EN
        chk("m_hwm",     32'(o_hwm),       32'(m_hwm));
`endif
    end

    // One clock: inputs applied after a falling edge, outputs sampled at the next falling edge
    task automatic step(input bit wr, input logic [BW-1:0] d, input bit rd, input bit clr);
        i_wr      = wr;
        i_data    = d;
        i_rd      = rd;
        i_clr_err = clr;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst_n     = 1'b0;
        i_wr        = 1'b0;
        i_rd        = 1'b0;
        i_data      = '0;
        i_clr_err   = 1'b0;
        i_afull_lvl = 5'd12;
        repeat (2) @(negedge i_clk);
        chk("rst_fill",    32'(o_fill),    32'd0);
        chk("rst_empty_n", 32'(o_empty_n), 32'd0);
        chk("rst_data",    32'(o_data),    32'd0);
        chk("rst_status",  32'(o_status),  32'h4000);
        i_rst_n = 1'b1;

        // Fill 0x01..0x10
        for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0);
        chk("fill16_fill", 32'(o_fill),      32'd16);
        chk("fill16_full", 32'(o_full),      32'd1);
        chk("fill16_half", 32'(o_half_full), 32'd1);
        chk("fill16_ovfl", 32'(o_ovfl),      32'd0);
        chk("fill16_data", 32'(o_data),      32'h01);

        // Overflow on full, then drain in order
        step(1, 8'hAA, 0, 0);
        chk("ovf_ovfl",   32'(o_ovfl),      32'd1);
        chk("ovf_err",    32'(o_err),       32'd1);
        chk("ovf_stat2",  32'(o_status[2]), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            chk("drain_data", 32'(o_data), 32'(i));
            step(0, 8'h00, 1, 0);
        end
        chk("drain_empty", 32'(o_empty_n), 32'd0);

        // Refill (clearing the overflow on the way), then write+read while full
        step(1, 8'h01, 0, 1);
        for (int i = 2; i <= 16; i++) step(1, 8'(i), 0, 0);
        step(1, 8'h55, 1, 0);
        chk("fullrw_fill", 32'(o_fill), 32'd16);
        chk("fullrw_data", 32'(o_data), 32'h02);
        chk("fullrw_ovfl", 32'(o_ovfl), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) chk("fullrw_55", 32'(o_data), 32'h55);
            step(0, 8'h00, 1, 0);
        end

        // Empty with write+read: no bypass
        step(1, 8'h33, 1, 0);
        chk("emprw_unfl", 32'(o_unfl), 32'd1);
        chk("emprw_fill", 32'(o_fill), 32'd1);
        chk("emprw_data", 32'(o_data), 32'h33);
        step(0, 8'h00, 1, 1);
        chk("clr_unfl", 32'(o_unfl), 32'd0);
        chk("clr_fill", 32'(o_fill), 32'd0);

        // Almost-full threshold at 12
        for (int i = 0; i < 11; i++) step(1, 8'(8'h40 + i), 0, 0);
        chk("af11", 32'(o_afull), 32'd0);
        step(1, 8'h4B, 0, 0);
        chk("af12",      32'(o_afull),          32'd1);
        chk("af12_stat", 32'(o_status[11:3]),   32'd12);
        step(0, 8'h00, 1, 0);
        chk("af11_rd", 32'(o_afull), 32'd0);

        // Down to 7, restart the high-water mark, then asynchronous reset
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);
        chk("pre_rst_fill", 32'(o_fill), 32'd7);
`ifdef UFIFO_HWM_EN
        chk("pre_rst_hwm", 32'(o_hwm), 32'd7);
`endif
        i_wr = 1'b1;
        i_data = 8'h77;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_fill",    32'(o_fill),      32'd0);
        chk("arst_empty_n", 32'(o_empty_n),   32'd0);
        chk("arst_full",    32'(o_full),      32'd0);
        chk("arst_half",    32'(o_half_full), 32'd0);
        chk("arst_afull",   32'(o_afull),     32'd0);
        chk("arst_ovfl",    32'(o_ovfl),      32'd0);
        chk("arst_unfl",    32'(o_unfl),      32'd0);
        chk("arst_data",    32'(o_data),      32'd0);
`ifdef UFIFO_HWM_EN
        chk("arst_hwm",     32'(o_hwm),       32'd0);
`endif
        i_wr = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_afull_lvl = 5'd0;
        step(0, 8'h00, 0, 0);
        chk("lvl0_afull", 32'(o_afull), 32'd1);
        i_afull_lvl = 5'd17;
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
        chk("lvl17_afull", 32'(o_afull), 32'd0);

        // Randomized traffic with phases biased toward full and toward empty
        for (int blk = 0; blk < 6; blk++) begin
            int unsigned wp;
            int unsigned rp;
            wp = (blk % 3 == 0) ? 80 : ((blk % 3 == 1) ? 25 : 50);
            rp = (blk % 3 == 0) ? 25 : ((blk % 3 == 1) ? 80 : 50);
            for (int c = 0; c < 500; c++) begin
                if (c % 50 == 0) i_afull_lvl = 5'($urandom_range(0, FLEN + 2));
                step(($urandom % 100) < wp, 8'($urandom), ($urandom % 100) < rp,
                     ($urandom % 16) == 0);
            end
        end
        step(0, 8'h00, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ufifo_lvl.md
Name: ufifo_lvl

Overview:
Parametrised successor to the UART byte FIFO, used on both the RX and TX paths of the next-generation UART and by other buffered peripherals. Synchronous single-clock FIFO, generic in width and depth. Holds all FLEN entries (no sacrificed slot) and presents a first-word-fall-through head. Adds an exact fill count, a programmable almost-full level, and sticky overflow/underflow flags with an explicit clear.

Parameters:
BW, 8, data width in bits (1..32)
LGFLEN, 4, log2 of depth; FLEN = 2^LGFLEN entries; legal range 2..8

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst_n  in  1  asynchronous, active-low reset
i_wr  in  1  write request
i_data  in  BW  write data
i_rd  in  1  read (pop) request
o_data  out  BW  head-of-queue word; valid while o_empty_n
o_empty_n  out  1  FIFO holds >= 1 entry
o_full  out  1  fill == FLEN
o_half_full  out  1  fill >= FLEN/2
i_afull_lvl  in  LGFLEN+1  almost-full threshold
o_afull  out  1  fill >= i_afull_lvl
o_fill  out  LGFLEN+1  current entry count, 0..FLEN
i_clr_err  in  1  synchronous clear of sticky error flags
o_ovfl  out  1  sticky: write rejected
o_unfl  out  1  sticky: read rejected
o_err  out  1  o_ovfl | o_unfl
o_status  out  16  packed status word

Behaviour:
- Reset (i_rst_n low, asynchronous): pointers = 0, o_fill = 0, o_empty_n = 0, o_full = 0, o_half_full = 0, o_afull = (i_afull_lvl == 0) after the first clock, o_ovfl = o_unfl = 0, o_data = 0. Memory contents are not reset. Reset mid-operation discards all contents; the first edge after release behaves as an empty FIFO.
- Pointers: write and read pointers are LGFLEN+1 bits wide. The MSB distinguishes full from empty. Wrap is natural modulo 2^(LGFLEN+1).
- Write accepted when i_wr && (!o_full || i_rd).
  - Full plus simultaneous read: both the write and the read are accepted, and fill is unchanged.
  - Rejected write: memory and pointers are untouched, and o_ovfl is set on the next edge.
- Read accepted when i_rd && o_empty_n.
  - Empty plus simultaneous write: no bypass. The read is rejected, o_unfl is set, and the write is accepted (fill becomes 1).
- o_fill is registered. Its next value is fill + accepted_wr - accepted_rd. All flags (o_empty_n, o_full, o_half_full, o_afull) are registered and derived from the next fill value, so they always match o_fill in the same cycle.
- Latency: a word written at edge N into an empty FIFO appears on o_data with o_empty_n = 1 after edge N. After an accepted read at edge N, o_data shows the next entry after edge N. If the FIFO is now empty, o_empty_n = 0 and o_data is don't-care.
- o_data is stable while no read is accepted, including during writes to a non-empty FIFO.
- i_afull_lvl is sampled every cycle. A value of 0 forces o_afull = 1; a value > FLEN forces o_afull = 0.
- Error flags:
  - i_clr_err clears o_ovfl and o_unfl on the next edge.
  - A new error in the same cycle as the clear wins, so the flag stays set.
  - o_err is combinational OR of the two flags.
- o_status layout:
  - [15:12] = LGFLEN
  - [11:3] = o_fill, zero-extended to 9 bits
  - [2] = o_err
  - [1] = o_half_full
  - [0] = o_empty_n

Optional Feature:
UFIFO_HWM_EN
- Defined: adds output o_hwm [LGFLEN+1 bits], a high-water mark.
  - Reset value is 0.
  - Each edge: o_hwm <= max(o_hwm, next fill).
  - i_clr_err also resets o_hwm to the next fill value.
  - o_status is unchanged.
- Not defined: port o_hwm is absent and no comparison logic is generated.

Test Plan:
- Reset, then BW=8 LGFLEN=4 and write 0x01..0x10 on 16 consecutive cycles -> o_fill=16, o_full=1, o_half_full=1, o_ovfl=0, o_data=0x01.
- Full, then write 0xAA with no read -> write rejected, o_ovfl=1, o_err=1, o_status[2]=1. Then 16 reads -> data returned is 0x01..0x10 and o_empty_n=0.
- Full, then simultaneous write 0x55 and read -> o_fill stays 16, o_data=0x02, o_ovfl=0. 0x55 emerges as the 16th subsequent read.
- Empty, then simultaneous write 0x33 and read -> o_unfl=1, o_fill=1, o_data=0x33. Next cycle, i_clr_err with i_rd on a non-empty FIFO -> o_unfl=0, o_fill=0.
- i_afull_lvl=12, then write 11 words -> o_afull=0. 12th word -> o_afull=1 and o_status[11:3]=12. One read -> o_afull=0.
- Pull i_rst_n low asynchronously mid-burst with fill=7 -> all outputs go to reset values immediately without a clock. With UFIFO_HWM_EN defined, o_hwm=7 before the reset and 0 after it.
